mccontrol_fsm: RTL and testbench

MCCONTROL_FSM -- requirements
Module: mccontrol_fsm

---
 rtl/mccontrol_pkg.sv | 109 ++++++++++
 rtl/mccontrol_fsm_decode.sv | 33 +++
 rtl/mccontrol_fsm.sv | 151 +++++++++++++++
 tb/tb_mccontrol_fsm.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mccontrol_pkg.sv
// Shared constants for the multicycle MIPS controller, datapath and ALU:
// state codes, opcode/function fields, ALU function codes and mux selects.
package mccontrol_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    // R-type function fields
    localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNC_W-1:0] FN_XOR = 6'b100110;
    localparam logic [FUNC_W-1:0] FN_SLL = 6'b000000;
    localparam logic [FUNC_W-1:0] FN_SRL = 6'b000010;
    localparam logic [FUNC_W-1:0] FN_SRA = 6'b000011;
    localparam logic [FUNC_W-1:0] FN_JR  = 6'b001000;

    // ALU function codes (don't-care MSBs resolved to 0)
    localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
    localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
    localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
    localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

    // ALU B-operand select
    localparam logic [SEL_W-1:0] SRCB_QB   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BR   = 2'b11;

    // Next-PC select
    localparam logic [SEL_W-1:0] PC_ALU   = 2'b00;
    localparam logic [SEL_W-1:0] PC_BTR   = 2'b01;
    localparam logic [SEL_W-1:0] PC_QA    = 2'b10;
    localparam logic [SEL_W-1:0] PC_JADDR = 2'b11;

    // One-hot instruction class produced by mc_decode
    typedef struct packed {
        logic rtype;
        logic shift;
        logic itype_alu;
        logic load;
        logic store;
        logic branch_eq;
        logic branch_ne;
        logic jump;
        logic jal;
        logic jr;
        logic illegal;
    } inst_class_t;

    // ALU function for the execute step of R-type and I-type ALU instructions
    function automatic logic [ALUC_W-1:0] exe_aluc(input logic [OP_W-1:0] op,
                                                   input logic [FUNC_W-1:0] func);
        logic [ALUC_W-1:0] code;
        code = ALUC_ADD;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_SUB:  code = ALUC_SUB;
                    FN_AND:  code = ALUC_AND;
                    FN_OR:   code = ALUC_OR;
                    FN_XOR:  code = ALUC_XOR;
                    FN_SLL:  code = ALUC_SLL;
                    FN_SRL:  code = ALUC_SRL;
                    FN_SRA:  code = ALUC_SRA;
                    default: code = ALUC_ADD;
                endcase
            end
            OP_ANDI: code = ALUC_AND;
            OP_ORI:  code = ALUC_OR;
            OP_XORI: code = ALUC_XOR;
            OP_LUI:  code = ALUC_LUI;
            default: code = ALUC_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mccontrol_fsm_decode.sv
// mc_decode: maps op/func to one-hot instruction-class flags.
// Ports: op, func (from IR) -> cls (exactly one flag set; illegal otherwise).
module mc_decode
    import mccontrol_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    output inst_class_t       cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: cls.rtype = 1'b1;
                    FN_SLL, FN_SRL, FN_SRA:                cls.shift = 1'b1;
                    FN_JR:                                 cls.jr    = 1'b1;
                    default:                               cls.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls.itype_alu = 1'b1;
            OP_LW:   cls.load      = 1'b1;
            OP_SW:   cls.store     = 1'b1;
            OP_BEQ:  cls.branch_eq = 1'b1;
            OP_BNE:  cls.branch_ne = 1'b1;
            OP_J:    cls.jump      = 1'b1;
            OP_JAL:  cls.jal       = 1'b1;
            default: cls.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/mccontrol_fsm.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer with
// combinational datapath controls.
// Ports: clk, clrn (async active-low); op, func, z, mem_rdy in;
// write enables wpc/wir/wmem/wreg; selects iord, regrt, m2reg, jal, sext,
// shift, alusrca, alusrcb, pcsrc; aluc; state (debug).
module mccontrol_fsm
    import mccontrol_pkg::*;
(
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNC_W-1:0]    func,
    input  logic                 z,
    input  logic                 mem_rdy,
    output logic                 wpc,
    output logic                 wir,
    output logic                 wmem,
    output logic                 wreg,
    output logic                 iord,
    output logic                 regrt,
    output logic                 m2reg,
    output logic                 jal,
    output logic                 sext,
    output logic                 shift,
    output logic                 alusrca,
    output logic [SEL_W-1:0]     alusrcb,
    output logic [SEL_W-1:0]     pcsrc,
    output logic [ALUC_W-1:0]    aluc,
    output logic [STATE_W-1:0]   state
);

    state_t      state_r;
    state_t      state_nxt;
    inst_class_t cls;
    logic        wpc_d;
    logic        wir_d;
    logic        wmem_d;
    logic        wreg_d;

    mc_decode u_decode (
        .op   (op),
        .func (func),
        .cls  (cls)
    );

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_r <= S_IF;
        else       state_r <= state_nxt;
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state_r;
        wpc_d     = 1'b0;
        wir_d     = 1'b0;
        wmem_d    = 1'b0;
        wreg_d    = 1'b0;
        iord      = 1'b0;
        regrt     = 1'b0;
        m2reg     = 1'b0;
        jal       = 1'b0;
        sext      = 1'b0;
        shift     = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = SRCB_QB;
        pcsrc     = PC_ALU;
        aluc      = ALUC_ADD;

        case (state_r)
            S_IF: begin
                alusrcb = SRCB_FOUR;
                if (mem_rdy) begin
                    wpc_d     = 1'b1;
                    wir_d     = 1'b1;
                    state_nxt = S_ID;
                end
            end
            S_ID: begin
                // Branch target computed here and latched by the datapath
                alusrcb = SRCB_BR;
                sext    = 1'b1;
                if (cls.jump) begin
                    wpc_d     = 1'b1;
                    pcsrc     = PC_JADDR;
                    state_nxt = S_IF;
                end else if (cls.jal) begin
                    wpc_d     = 1'b1;
                    pcsrc     = PC_JADDR;
                    wreg_d    = 1'b1;
                    jal       = 1'b1;
                    state_nxt = S_IF;
                end else if (cls.jr) begin
                    wpc_d     = 1'b1;
                    pcsrc     = PC_QA;
                    state_nxt = S_IF;
                end else if (cls.illegal) begin
                    state_nxt = S_IF;
                end else begin
                    state_nxt = S_EXE;
                end
            end
            S_EXE: begin
                if (cls.branch_eq || cls.branch_ne) begin
                    alusrca   = 1'b1;
                    aluc      = ALUC_SUB;
                    state_nxt = S_IF;
                    if ((cls.branch_eq && z) || (cls.branch_ne && !z)) begin
                        wpc_d = 1'b1;
                        pcsrc = PC_BTR;
                    end
                end else if (cls.load || cls.store) begin
                    alusrcb   = SRCB_IMM;
                    sext      = 1'b1;
                    state_nxt = S_MEM;
                end else if (cls.rtype || cls.shift || cls.itype_alu) begin
                    aluc      = exe_aluc(op, func);
                    shift     = cls.shift;
                    alusrcb   = cls.itype_alu ? SRCB_IMM : SRCB_QB;
                    // Logical immediates and lui are zero-extended
                    sext      = (op == OP_ADDI);
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_IF;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (mem_rdy) begin
                    wmem_d    = cls.store;
                    state_nxt = cls.load ? S_WB : S_IF;
                end
            end
            S_WB: begin
                wreg_d    = 1'b1;
                regrt     = cls.itype_alu || cls.load;
                m2reg     = cls.load;
                state_nxt = S_IF;
            end
            default: state_nxt = S_IF;
        endcase
    end

    // Reset masks the write enables in the same cycle it is asserted
    assign wpc   = wpc_d  & clrn;
    assign wir   = wir_d  & clrn;
    assign wmem  = wmem_d & clrn;
    assign wreg  = wreg_d & clrn;
    assign state = state_r;

endmodule

// File: tb/tb_mccontrol_fsm.sv
// Self-checking bench for mccontrol_fsm: directed scenarios plus randomized
// instruction streams checked against a per-instruction path model.
module tb_mccontrol_fsm;
    import mccontrol_pkg::*;

    logic       clk = 1'b0;
    logic       clrn;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_rdy;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluc;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;

    localparam int I_ADD = 0, I_SUB = 1, I_AND = 2, I_OR = 3, I_XOR = 4;
    localparam int I_SLL = 5, I_SRL = 6, I_SRA = 7, I_JR = 8;
    localparam int I_ADDI = 9, I_ANDI = 10, I_ORI = 11, I_XORI = 12, I_LUI = 13;
    localparam int I_LW = 14, I_SW = 15, I_BEQ = 16, I_BNE = 17, I_J = 18, I_JAL = 19;
    localparam int I_NOP = 20, N_INS = 21;

    localparam int ST_IF = 0, ST_ID = 1, ST_EXE = 2, ST_MEM = 3, ST_WB = 4;

    mccontrol_fsm dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
        .m2reg(m2reg), .jal(jal), .sext(sext), .shift(shift), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluc(aluc), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // MIPS encodings; func is random wherever the opcode does not use it
    task automatic encode(input int ins, input logic alt, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        o = 6'h00;
        case (ins)
            I_ADD:  f = 6'h20;
            I_SUB:  f = 6'h22;
            I_AND:  f = 6'h24;
            I_OR:   f = 6'h25;
            I_XOR:  f = 6'h26;
            I_SLL:  f = 6'h00;
            I_SRL:  f = 6'h02;
            I_SRA:  f = 6'h03;
            I_JR:   f = 6'h08;
            I_ADDI: o = 6'h08;
            I_ANDI: o = 6'h0c;
            I_ORI:  o = 6'h0d;
            I_XORI: o = 6'h0e;
            I_LUI:  o = 6'h0f;
            I_LW:   o = 6'h23;
            I_SW:   o = 6'h2b;
            I_BEQ:  o = 6'h04;
            I_BNE:  o = 6'h05;
            I_J:    o = 6'h02;
            I_JAL:  o = 6'h03;
            default: begin
                if (alt) f = 6'h3f;
                else     o = 6'h3f;
            end
        endcase
    endtask

    function automatic logic [3:0] alu_code(input int ins);
        case (ins)
            I_SUB:          return 4'b0100;
            I_AND, I_ANDI:  return 4'b0001;
            I_OR, I_ORI:    return 4'b0101;
            I_XOR, I_XORI:  return 4'b0010;
            I_LUI:          return 4'b0110;
            I_SLL:          return 4'b0011;
            I_SRL:          return 4'b0111;
            I_SRA:          return 4'b1111;
            default:        return 4'b0000;
        endcase
    endfunction

    // Expected {wpc,wir,wmem,wreg,iord,regrt,m2reg,jal,sext,shift,alusrca,alusrcb,pcsrc,aluc}
    function automatic logic [18:0] exp_out(input int stg, input int ins, input logic zz, input logic rdy);
        logic e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal, e_sext, e_shift, e_asa;
        logic [1:0] e_b, e_pc;
        logic [3:0] e_alu;
        logic is_itype, is_shift, taken;
        {e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal, e_sext, e_shift, e_asa} = '0;
        e_b = 2'b00; e_pc = 2'b00; e_alu = 4'b0000;
        is_itype = (ins >= I_ADDI && ins <= I_LUI);
        is_shift = (ins >= I_SLL && ins <= I_SRA);
        case (stg)
            ST_IF: begin
                e_b = 2'b01; e_wpc = rdy; e_wir = rdy;
            end
            ST_ID: begin
                e_b = 2'b11; e_sext = 1'b1;
                if (ins == I_J)   begin e_wpc = 1'b1; e_pc = 2'b11; end
                if (ins == I_JAL) begin e_wpc = 1'b1; e_pc = 2'b11; e_wreg = 1'b1; e_jal = 1'b1; end
                if (ins == I_JR)  begin e_wpc = 1'b1; e_pc = 2'b10; end
            end
            ST_EXE: begin
                if (ins == I_BEQ || ins == I_BNE) begin
                    e_asa = 1'b1; e_alu = 4'b0100;
                    taken = (ins == I_BEQ) ? zz : !zz;
                    e_wpc = taken;
                    e_pc  = taken ? 2'b01 : 2'b00;
                end else if (ins == I_LW || ins == I_SW) begin
                    e_b = 2'b10; e_sext = 1'b1;
                end else begin
                    e_alu = alu_code(ins); e_shift = is_shift;
                    e_b = is_itype ? 2'b10 : 2'b00;
                    e_sext = (ins == I_ADDI);
                end
            end
            ST_MEM: begin
                e_iord = 1'b1; e_wmem = (ins == I_SW) && rdy;
            end
            ST_WB: begin
                e_wreg = 1'b1; e_regrt = is_itype || ins == I_LW; e_m2reg = (ins == I_LW);
            end
            default: ;
        endcase
        return {e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal, e_sext, e_shift,
                e_asa, e_b, e_pc, e_alu};
    endfunction

    // Instruction paths: IF and MEM wait on mem_rdy, other steps take one cycle
    function automatic int next_stage(input int stg, input int ins, input logic rdy);
        case (stg)
            ST_IF:  return rdy ? ST_ID : ST_IF;
            ST_ID:  return (ins == I_J || ins == I_JAL || ins == I_JR || ins == I_NOP) ? ST_IF : ST_EXE;
            ST_EXE: return (ins == I_BEQ || ins == I_BNE) ? ST_IF :
                           (ins == I_LW || ins == I_SW) ? ST_MEM : ST_WB;
            ST_MEM: return rdy ? ((ins == I_LW) ? ST_WB : ST_IF) : ST_MEM;
            default: return ST_IF;
        endcase
    endfunction

    function automatic int base_cpi(input int ins);
        case (ins)
            I_J, I_JAL, I_JR, I_NOP: return 2;
            I_BEQ, I_BNE:            return 3;
            I_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Drives one instruction from IF back to IF, checking every cycle and the CPI
    task automatic run_instr(input int ins, input logic zz, input int if_st, input int mem_st, input string tag);
        int stg, prev, cycles, if_n, mem_n, want_cyc;
        logic rdy, done, alt;
        logic [5:0] o, f;
        logic [21:0] exp_v, obs_v;
        stg = ST_IF; cycles = 0; if_n = 0; mem_n = 0; done = 1'b0;
        alt = 1'($urandom);
        encode(ins, alt, o, f);
        while (!done && cycles < 24) begin
            @(negedge clk);
            if (stg == ST_IF) begin
                rdy = (if_n >= if_st); if_n++;
            end else if (stg == ST_MEM) begin
                rdy = (mem_n >= mem_st); mem_n++;
            end else begin
                rdy = 1'($urandom);
            end
            op = o; func = f; z = zz; mem_rdy = rdy;
            #1;
            exp_v = {3'(stg), exp_out(stg, ins, zz, rdy)};
            obs_v = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
                     alusrca, alusrcb, pcsrc, aluc};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d {state,ctl}: got %h expected %h", tag, cycles, obs_v, exp_v);
            end
            @(posedge clk);
            prev = stg;
            stg = next_stage(stg, ins, rdy);
            cycles++;
            if (stg == ST_IF && prev != ST_IF) done = 1'b1;
        end
        want_cyc = base_cpi(ins) + if_st + ((ins == I_LW || ins == I_SW) ? mem_st : 0);
        vectors++;
        if (!done || cycles != want_cyc) begin
            miscompares++;
            $display("FAIL %s cpi: got %0d cycles (done=%0b) expected %0d", tag, cycles, done, want_cyc);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; op = 6'h00; func = 6'h20; z = 1'b0; mem_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if (state !== 3'b000) begin
            miscompares++; $display("FAIL reset_state: got %b expected 000", state);
        end
        vectors++;
        if ({wpc, wir, wmem, wreg} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_enables: got %b expected 0000", {wpc, wir, wmem, wreg});
        end
        mem_rdy = 1'b0; clrn = 1'b1; #1;
        vectors++;
        if (state !== 3'b000 || wpc !== 1'b0) begin
            miscompares++; $display("FAIL reset_release: state %b wpc %b expected 000/0", state, wpc);
        end
        @(posedge clk);
    endtask

    task automatic test_add();
        run_instr(I_ADD, 1'b0, 0, 0, "add");
    endtask

    task automatic test_lw_stall();
        run_instr(I_LW, 1'b0, 0, 2, "lw_stall");
        run_instr(I_SW, 1'b1, 1, 1, "sw_stall");
    endtask

    task automatic test_branch();
        run_instr(I_BEQ, 1'b1, 0, 0, "beq_taken");
        run_instr(I_BNE, 1'b1, 0, 0, "bne_not_taken");
        run_instr(I_BEQ, 1'b0, 0, 0, "beq_not_taken");
        run_instr(I_BNE, 1'b0, 0, 0, "bne_taken");
    endtask

    task automatic test_jumps();
        run_instr(I_JAL, 1'b0, 0, 0, "jal");
        run_instr(I_J,   1'b0, 0, 0, "j");
        run_instr(I_JR,  1'b0, 0, 0, "jr");
    endtask

    task automatic test_sw_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = 6'h2b; func = 6'($urandom); mem_rdy = 1'b1;
            @(posedge clk);
        end
        @(negedge clk); mem_rdy = 1'b1; #1;
        vectors++;
        if (state !== 3'b011 || wmem !== 1'b1) begin
            miscompares++; $display("FAIL sw_mem_pre: state %b wmem %b expected 011/1", state, wmem);
        end
        clrn = 1'b0; #1;
        vectors++;
        if (wmem !== 1'b0 || state !== 3'b000) begin
            miscompares++; $display("FAIL sw_reset_now: state %b wmem %b expected 000/0", state, wmem);
        end
        @(posedge clk);
        @(negedge clk); mem_rdy = 1'b1; #1;
        vectors++;
        if ({wpc, wir, wmem, wreg} !== 4'b0000 || state !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold: enables %b state %b expected 0000/000", {wpc, wir, wmem, wreg}, state);
        end
        mem_rdy = 1'b0; clrn = 1'b1; #1;
        vectors++;
        if (wpc !== 1'b0) begin
            miscompares++; $display("FAIL fetch_wait: wpc %b expected 0", wpc);
        end
        @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if (state !== 3'b000) begin
            miscompares++; $display("FAIL fetch_hold: state %b expected 000", state);
        end
        mem_rdy = 1'b1; #1;
        vectors++;
        if ({wpc, wir} !== 2'b11) begin
            miscompares++; $display("FAIL fetch_resume: wpc/wir %b expected 11", {wpc, wir});
        end
        @(posedge clk);
        @(negedge clk); op = 6'h3f; #1;
        vectors++;
        if (state !== 3'b001) begin
            miscompares++; $display("FAIL resume_id: state %b expected 001", state);
        end
        @(posedge clk);
    endtask

    task automatic test_nop_illegal();
        run_instr(I_NOP, 1'b0, 0, 0, "nop");
        run_instr(I_NOP, 1'b1, 1, 0, "nop_stall");
        @(negedge clk);
        op = 6'h00; func = 6'h20; mem_rdy = 1'b1;
        force dut.state_r = state_t'(3'b101);
        #1;
        vectors++;
        if (state !== 3'b101 || {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
                                 alusrca, alusrcb, pcsrc, aluc} !== 19'd0) begin
            miscompares++;
            $display("FAIL illegal_state_outputs: state %b wpc %b wir %b expected 101 with all zero",
                     state, wpc, wir);
        end
        release dut.state_r;
        mem_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if (state !== 3'b000) begin
            miscompares++; $display("FAIL illegal_recover: state %b expected 000", state);
        end
        @(posedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            run_instr(int'($urandom_range(N_INS - 1, 0)), 1'($urandom),
                      int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_branch();
        test_jumps();
        test_sw_reset();
        test_nop_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
